// File: rtl/commit_trace_fifo.sv
// Show-ahead FIFO of per-cycle retire records (pc, instr, result, wen) tagged with a sequence number.
// Optional macro TRACE_WB_ONLY_EN: only commits with commit_wen=1 are stored.
module commit_trace_fifo #(
    parameter int XLEN   = 32,
    parameter int DEPTH  = 8,
    parameter int SEQ_W  = 16,
    parameter int DROP_W = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     commit_valid,
    input  logic [XLEN-1:0]          commit_pc,
    input  logic [XLEN-1:0]          commit_instr,
    input  logic [XLEN-1:0]          commit_result,
    input  logic                     commit_wen,
    output logic                     trace_valid,
    input  logic                     trace_ready,
    output logic [SEQ_W-1:0]         trace_seq,
    output logic [XLEN-1:0]          trace_pc,
    output logic [XLEN-1:0]          trace_instr,
    output logic [XLEN-1:0]          trace_result,
    output logic                     trace_wen,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic [DROP_W-1:0]        drop_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int EW = SEQ_W + 3 * XLEN + 1;
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [EW-1:0]     mem [DEPTH];
    logic [AW-1:0]     rd_ptr;
    logic [AW-1:0]     wr_ptr;
    logic [AW:0]       count;
    logic [SEQ_W-1:0]  seq;
    logic [DROP_W-1:0] drops;

    logic capture;
    logic full;
    logic pop;
    logic push;
    logic drop;

    logic [SEQ_W-1:0] h_seq;
    logic [XLEN-1:0]  h_pc;
    logic [XLEN-1:0]  h_instr;
    logic [XLEN-1:0]  h_result;
    logic             h_wen;

    function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

`ifdef TRACE_WB_ONLY_EN
    assign capture = commit_valid & commit_wen;
`else
    assign capture = commit_valid;
`endif

    assign full        = (count == FULL_CNT);
    assign trace_valid = (count != '0);
    assign pop         = trace_valid & trace_ready;
    // A full FIFO can still accept when the head leaves in the same cycle.
    assign push        = capture & (~full | pop);
    assign drop        = capture & full & ~pop;

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            seq    <= '0;
            drops  <= '0;
        end else begin
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            // Sequence advances on every retire so gaps reveal filtered or dropped commits.
            if (commit_valid)
                seq <= seq + 1'b1;
            if (drop)
                drops <= sat_inc(drops);
        end
    end

    // Storage holds data only; it is not reset, emptiness is tracked by count.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= {seq, commit_pc, commit_instr, commit_result, commit_wen};
    end

    assign {h_seq, h_pc, h_instr, h_result, h_wen} = mem[rd_ptr];

    assign trace_seq    = trace_valid ? h_seq    : '0;
    assign trace_pc     = trace_valid ? h_pc     : '0;
    assign trace_instr  = trace_valid ? h_instr  : '0;
    assign trace_result = trace_valid ? h_result : '0;
    assign trace_wen    = trace_valid & h_wen;
    assign fifo_count   = count;
    assign drop_count   = drops;
endmodule

// File: tb/tb_commit_trace_fifo.sv
// Randomized bench for commit_trace_fifo against a queue-based reference model.
module tb_commit_trace_fifo;
    localparam int XLEN = 32, DEPTH = 8, SEQ_W = 16, DROP_W = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic              commit_valid;
    logic [XLEN-1:0]   commit_pc;
    logic [XLEN-1:0]   commit_instr;
    logic [XLEN-1:0]   commit_result;
    logic              commit_wen;
    logic              trace_valid;
    logic              trace_ready;
    logic [SEQ_W-1:0]  trace_seq;
    logic [XLEN-1:0]   trace_pc;
    logic [XLEN-1:0]   trace_instr;
    logic [XLEN-1:0]   trace_result;
    logic              trace_wen;
    logic [3:0]        fifo_count;
    logic [DROP_W-1:0] drop_count;

    commit_trace_fifo #(.XLEN(XLEN), .DEPTH(DEPTH), .SEQ_W(SEQ_W), .DROP_W(DROP_W)) dut (
        .clk(clk), .reset(reset),
        .commit_valid(commit_valid), .commit_pc(commit_pc), .commit_instr(commit_instr),
        .commit_result(commit_result), .commit_wen(commit_wen),
        .trace_valid(trace_valid), .trace_ready(trace_ready), .trace_seq(trace_seq),
        .trace_pc(trace_pc), .trace_instr(trace_instr), .trace_result(trace_result),
        .trace_wen(trace_wen), .fifo_count(fifo_count), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [SEQ_W-1:0] seq;
        logic [XLEN-1:0]  pc;
        logic [XLEN-1:0]  instr;
        logic [XLEN-1:0]  result;
        logic             wen;
    } rec_t;

    rec_t             q[$];
    logic [SEQ_W-1:0] m_seq;
    int               m_drops;
    int               checks = 0;
    int               errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic bit captured(input bit v, input bit w);
`ifdef TRACE_WB_ONLY_EN
        return v && w;
`else
        return v;
`endif
    endfunction

    task automatic compare_all();
        chk("valid", trace_valid, q.size() != 0);
        chk("count", fifo_count, q.size());
        chk("drops", drop_count, m_drops);
        if (q.size() != 0) begin
            chk("seq", trace_seq, q[0].seq);
            chk("pc", trace_pc, q[0].pc);
            chk("instr", trace_instr, q[0].instr);
            chk("result", trace_result, q[0].result);
            chk("wen", trace_wen, q[0].wen);
        end else begin
            chk("empty_fields", {trace_seq, trace_pc, trace_wen}, 0);
            chk("empty_instr_res", {trace_instr, trace_result}, 0);
        end
    endtask

    // One clock: drive inputs, advance the model at the edge, check just after it.
    task automatic step(input bit rst, input bit v, input bit w, input bit rdy,
                        input logic [XLEN-1:0] pc, input logic [XLEN-1:0] ins,
                        input logic [XLEN-1:0] res);
        bit popped;
        reset = rst; commit_valid = v; commit_wen = w; trace_ready = rdy;
        commit_pc = pc; commit_instr = ins; commit_result = res;
        @(posedge clk);
        if (rst) begin
            q.delete(); m_seq = '0; m_drops = 0;
        end else begin
            popped = (q.size() != 0) && rdy;
            if (popped) void'(q.pop_front());
            if (captured(v, w)) begin
                if (q.size() < DEPTH) q.push_back('{m_seq, pc, ins, res, w});
                else if (m_drops < (1 << DROP_W) - 1) m_drops++;
            end
            if (v) m_seq = m_seq + 1'b1;
        end
        #1;
        compare_all();
    endtask

    task automatic rstep(input bit rst, input bit v, input bit w, input bit rdy);
        step(rst, v, w, rdy, $urandom, $urandom, $urandom);
    endtask

    initial begin
        m_seq = '0; m_drops = 0;
        // Reset held two cycles while commits arrive.
        rstep(1, 1, 1, 0);
        rstep(1, 1, 1, 0);
        chk("rst_valid", trace_valid, 0);
        chk("rst_count", fifo_count, 0);
        // Single pass: visible next cycle with seq 0, gone after pop.
        step(0, 1, 1, 1, 32'h10, 32'h0050_0093, 32'd5);
        chk("t2_seq", trace_seq, 0);
        chk("t2_pc", trace_pc, 32'h10);
        chk("t2_instr", trace_instr, 32'h0050_0093);
        rstep(0, 0, 0, 1);
        chk("t2_empty", trace_valid, 0);

        // Fill and overflow.
        rstep(1, 0, 0, 0);
        for (int i = 0; i < 10; i++) rstep(0, 1, 1, 0);
        chk("t3_count", fifo_count, 8);
        chk("t3_drops", drop_count, 2);
        for (int i = 0; i < 8; i++) begin
            chk("t3_drain_seq", trace_seq, i);
            rstep(0, 0, 0, 1);
        end
        rstep(0, 1, 1, 0);
        chk("t3_next_seq", trace_seq, 10);

        // Full with simultaneous pop.
        rstep(1, 0, 0, 0);
        for (int i = 0; i < 8; i++) rstep(0, 1, 1, 0);
        rstep(0, 1, 1, 1);
        chk("t4_count", fifo_count, 8);
        chk("t4_drops", drop_count, 0);

        // Write-back filter pattern wen=1,0,1.
        rstep(1, 0, 0, 0);
        rstep(0, 1, 1, 0);
        rstep(0, 1, 0, 0);
        rstep(0, 1, 1, 0);
`ifdef TRACE_WB_ONLY_EN
        chk("t6_count", fifo_count, 2);
`else
        chk("t6_count", fifo_count, 3);
`endif

        // Toggling backpressure over 20 commits.
        rstep(1, 0, 0, 0);
        for (int i = 0; i < 40; i++) rstep(0, i < 20, 1, i[0] == 1'b0);

        // Random traffic with varying consumer speed and occasional resets.
        for (int ph = 0; ph < 4; ph++)
            for (int i = 0; i < 250; i++)
                rstep($urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0,
                      $urandom_range(0, 1), $urandom_range(0, 3) < ph + 1);

        // Drop counter saturation.
        rstep(1, 0, 0, 0);
        for (int i = 0; i < 300; i++) rstep(0, 1, 1, 0);
        chk("sat_drops", drop_count, 255);
        for (int i = 0; i < 12; i++) rstep(0, $urandom_range(0, 1), 1, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
